// File: rtl/johnson_phase_decoder.sv
// Decodes a registered W-bit Johnson counter code to a phase index and a one-hot strobe.
// It also tracks sequence lock, the wrap pulse and a saturating step-error count.
module johnson_phase_decoder #(
   parameter int unsigned W        = 4,
   parameter int unsigned LOCK_CNT = 3,
   parameter int unsigned CW       = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [W-1:0]             in_code,
   input  logic                     err_clr,
   output logic                     out_valid,
   output logic [$clog2(2*W)-1:0]   phase,
   output logic [2*W-1:0]           phase_onehot,
   output logic                     illegal,
   output logic                     skip,
   output logic                     wrap,
   output logic                     locked,
   output logic [CW-1:0]            err_count
);

   localparam int unsigned PW = $clog2(2*W);
   localparam int unsigned NP = 2*W;
   localparam int unsigned RW = $clog2(LOCK_CNT+1);

   typedef enum logic [0:0] {HUNT, LOCKED} state_e;

   state_e         state_q;
   logic           out_valid_q;
   logic [PW-1:0]  phase_q;
   logic [NP-1:0]  onehot_q;
   logic           illegal_q;
   logic           skip_q;
   logic           wrap_q;
   logic           locked_q;
   logic [CW-1:0]  err_q;
   logic           prev_valid_q;
   logic [RW-1:0]  run_q;

   logic [PW-1:0]  pop_c;
   logic [PW-1:0]  phase_c;
   logic [W-1:0]   regen_c;
   logic           legal_c;
   logic [PW-1:0]  succ_c;
   logic           good_c;
   logic [NP-1:0]  onehot_c;
   logic [RW-1:0]  run_d;
   logic           err_bump_c;
   logic [CW-1:0]  err_d;

   // Decode phase from popcount, then regenerate the code to check legality.
   always_comb begin
      pop_c = '0;
      for (int i = 0; i < int'(W); i++) begin
         pop_c = pop_c + PW'(in_code[i]);
      end
      if (in_code[W-1] || (in_code == '0)) begin
         phase_c = pop_c;
      end else begin
         phase_c = PW'(NP) - pop_c;
      end
      if (phase_c <= PW'(W)) begin
         regen_c = ~({W{1'b1}} >> phase_c);
      end else begin
         regen_c = {W{1'b1}} >> (phase_c - PW'(W));
      end
      legal_c  = (regen_c == in_code);
      onehot_c = NP'(1) << phase_c;
   end

   // phase_q doubles as the previous phase; prev_valid_q says whether it counts.
   always_comb begin
      succ_c     = (phase_q == PW'(NP-1)) ? '0 : phase_q + PW'(1);
      good_c     = prev_valid_q && legal_c && (phase_c == succ_c);
      run_d      = !good_c ? RW'(1) :
                   (run_q >= RW'(LOCK_CNT)) ? run_q : run_q + RW'(1);
      err_bump_c = in_valid && (state_q == LOCKED) && !good_c;
      err_d      = (err_q == '1) ? err_q : err_q + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= HUNT;
         out_valid_q  <= 1'b0;
         phase_q      <= '0;
         onehot_q     <= '0;
         illegal_q    <= 1'b0;
         skip_q       <= 1'b0;
         wrap_q       <= 1'b0;
         locked_q     <= 1'b0;
         err_q        <= '0;
         prev_valid_q <= 1'b0;
         run_q        <= '0;
      end else begin
         illegal_q <= 1'b0;
         skip_q    <= 1'b0;
         wrap_q    <= 1'b0;
         if (in_valid) begin
            if (!legal_c) begin
               out_valid_q  <= 1'b0;
               onehot_q     <= '0;
               illegal_q    <= 1'b1;
               prev_valid_q <= 1'b0;
               run_q        <= '0;
               state_q      <= HUNT;
               locked_q     <= 1'b0;
            end else begin
               out_valid_q  <= 1'b1;
               phase_q      <= phase_c;
               onehot_q     <= onehot_c;
               prev_valid_q <= 1'b1;
               if (state_q == HUNT) begin
                  run_q  <= run_d;
                  skip_q <= prev_valid_q && !good_c;
                  if (run_d >= RW'(LOCK_CNT)) begin
                     state_q  <= LOCKED;
                     locked_q <= 1'b1;
                  end
               end else if (good_c) begin
                  wrap_q <= (phase_q == PW'(NP-1)) && (phase_c == '0);
               end else begin
                  state_q  <= HUNT;
                  locked_q <= 1'b0;
                  skip_q   <= 1'b1;
                  run_q    <= RW'(1);
               end
            end
         end
         // Clear takes priority over a same-cycle error increment.
         if (err_clr) begin
            err_q <= '0;
         end else if (err_bump_c) begin
            err_q <= err_d;
         end
      end
   end

   assign out_valid    = out_valid_q;
   assign phase        = phase_q;
   assign phase_onehot = onehot_q;
   assign illegal      = illegal_q;
   assign skip         = skip_q;
   assign wrap         = wrap_q;
   assign locked       = locked_q;
   assign err_count    = err_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder: decode, lock, skip/illegal, hold, async reset, saturation.
module tb_johnson_phase_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] in_code = '0;
   logic       err_clr = 1'b0;
   logic       out_valid;
   logic [2:0] phase;
   logic [7:0] phase_onehot;
   logic       illegal, skip, wrap, locked;
   logic [7:0] err_count;

   logic       in_valid2 = 1'b0;
   logic [3:0] in_code2 = '0;
   logic       err_clr2 = 1'b0;
   logic       out_valid2;
   logic [2:0] phase2;
   logic [7:0] phase_onehot2;
   logic       illegal2, skip2, wrap2, locked2;
   logic [1:0] err_count2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   johnson_phase_decoder #(.W(4), .LOCK_CNT(3), .CW(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .err_clr(err_clr),
      .out_valid(out_valid), .phase(phase), .phase_onehot(phase_onehot),
      .illegal(illegal), .skip(skip), .wrap(wrap), .locked(locked), .err_count(err_count)
   );

   johnson_phase_decoder #(.W(4), .LOCK_CNT(1), .CW(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_code(in_code2), .err_clr(err_clr2),
      .out_valid(out_valid2), .phase(phase2), .phase_onehot(phase_onehot2),
      .illegal(illegal2), .skip(skip2), .wrap(wrap2), .locked(locked2), .err_count(err_count2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [3:0] c);
      in_valid = v;
      in_code  = c;
      @(posedge clk);
      #1;
   endtask

   task automatic step2(input logic [3:0] c, input logic clr);
      in_valid2 = 1'b1;
      in_code2  = c;
      err_clr2  = clr;
      @(posedge clk);
      #1;
   endtask

   // Full-state check of the main instance.
   task automatic chk_all(input string tag, input logic ov, input logic [2:0] ph, input logic [7:0] oh,
                          input logic il, input logic sk, input logic wr, input logic lk,
                          input logic [7:0] ec);
      chk({tag, ".out_valid"}, out_valid, ov);
      chk({tag, ".phase"}, phase, ph);
      chk({tag, ".onehot"}, phase_onehot, oh);
      chk({tag, ".illegal"}, illegal, il);
      chk({tag, ".skip"}, skip, sk);
      chk({tag, ".wrap"}, wrap, wr);
      chk({tag, ".locked"}, locked, lk);
      chk({tag, ".err"}, err_count, ec);
   endtask

   initial begin
      logic [3:0] run_codes [7];
      logic [2:0] run_ph    [7];
      run_codes = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000, 4'b1100};
      run_ph    = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};

      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 0, 0, 8'h00, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;

      // 1: acquire lock on the third consecutive good code
      step(1, 4'b0000); chk_all("t1.p0", 1, 0, 8'h01, 0, 0, 0, 0, 0);
      step(1, 4'b1000); chk_all("t1.p1", 1, 1, 8'h02, 0, 0, 0, 0, 0);
      step(1, 4'b1100); chk_all("t1.p2", 1, 2, 8'h04, 0, 0, 0, 1, 0);

      // 2: walk through the ring, wrap only on 7 -> 0
      step(1, 4'b1110); chk_all("t2.p3", 1, 3, 8'h08, 0, 0, 0, 1, 0);
      step(1, 4'b1111); chk_all("t2.p4", 1, 4, 8'h10, 0, 0, 0, 1, 0);
      step(1, 4'b0111); chk_all("t2.p5", 1, 5, 8'h20, 0, 0, 0, 1, 0);
      step(1, 4'b0011); chk_all("t2.p6", 1, 6, 8'h40, 0, 0, 0, 1, 0);
      step(1, 4'b0001); chk_all("t2.p7", 1, 7, 8'h80, 0, 0, 0, 1, 0);
      step(1, 4'b0000); chk_all("t2.wrap", 1, 0, 8'h01, 0, 0, 1, 1, 0);
      step(1, 4'b1000); chk_all("t2.p1", 1, 1, 8'h02, 0, 0, 0, 1, 0);
      step(1, 4'b1100); chk_all("t2.p2", 1, 2, 8'h04, 0, 0, 0, 1, 0);

      // 3: illegal code while locked, then relock
      step(1, 4'b0101); chk_all("t3.ill", 0, 2, 8'h00, 1, 0, 0, 0, 1);
      step(1, 4'b1000); chk_all("t3.r1", 1, 1, 8'h02, 0, 0, 0, 0, 1);
      step(1, 4'b1100); chk_all("t3.r2", 1, 2, 8'h04, 0, 0, 0, 0, 1);
      step(1, 4'b1110); chk_all("t3.r3", 1, 3, 8'h08, 0, 0, 0, 1, 1);

      for (int i = 0; i < 7; i++) begin
         step(1, run_codes[i]);
         chk($sformatf("t3.walk%0d.phase", i), phase, run_ph[i]);
         chk($sformatf("t3.walk%0d.locked", i), locked, 1'b1);
      end

      // 4: skip from phase 2 to 4, relock counting the skipped-to code
      step(1, 4'b1111); chk_all("t4.skip", 1, 4, 8'h10, 0, 1, 0, 0, 2);
      step(1, 4'b0111); chk_all("t4.r1", 1, 5, 8'h20, 0, 0, 0, 0, 2);
      step(1, 4'b0011); chk_all("t4.r2", 1, 6, 8'h40, 0, 0, 0, 1, 2);

      // 5: idle cycles hold outputs and clear the wrap pulse
      step(1, 4'b0001); chk_all("t5.p7", 1, 7, 8'h80, 0, 0, 0, 1, 2);
      step(1, 4'b0000); chk_all("t5.wrap", 1, 0, 8'h01, 0, 0, 1, 1, 2);
      for (int i = 0; i < 3; i++) begin
         step(0, 4'b0101);
         chk_all($sformatf("t5.idle%0d", i), 1, 0, 8'h01, 0, 0, 0, 1, 2);
      end
      #2 rst = 1'b1;
      #1 chk_all("t5.arst", 0, 0, 8'h00, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      step(1, 4'b1100); chk_all("t5.first", 1, 2, 8'h04, 0, 0, 0, 0, 0);
      in_valid = 1'b0;

      // 6: CW=2, LOCK_CNT=1 -- repeated code alternates lock / error
      step2(4'b0000, 0); chk("t6.s1.lk", locked2, 1); chk("t6.s1.err", err_count2, 0);
      step2(4'b0000, 0); chk("t6.s2.lk", locked2, 0); chk("t6.s2.err", err_count2, 1);
      chk("t6.s2.skip", skip2, 1);
      step2(4'b0000, 0); chk("t6.s3.lk", locked2, 1); chk("t6.s3.err", err_count2, 1);
      step2(4'b0000, 0); chk("t6.s4.err", err_count2, 2);
      step2(4'b0000, 0); chk("t6.s5.lk", locked2, 1);
      step2(4'b0000, 0); chk("t6.s6.err", err_count2, 3);
      step2(4'b0000, 0); chk("t6.s7.lk", locked2, 1);
      step2(4'b0000, 0); chk("t6.sat.err", err_count2, 3); chk("t6.sat.lk", locked2, 0);
      step2(4'b0000, 0); chk("t6.s9.lk", locked2, 1);
      step2(4'b0000, 1); chk("t6.clr.err", err_count2, 0); chk("t6.clr.skip", skip2, 1);
      chk("t6.clr.lk", locked2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
